// File: rtl/j1_dbus_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : j1_dbus_uart_pkg
// Purpose  : Register offsets, STATUS bit positions and UART state type
// Revision : 1.0 - initial release
// ============================================================================
package j1_dbus_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int ST_TX_IDLE  = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_VALID = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_DROP  = 4;
    localparam int ST_RX_OVR   = 5;

    localparam logic [15:0] DIV_MIN       = 16'd4;
    localparam logic [15:0] RX_EMPTY_WORD = 16'h8000;

    typedef enum logic [1:0] {
        US_IDLE  = 2'd0,
        US_START = 2'd1,
        US_DATA  = 2'd2,
        US_STOP  = 2'd3
    } uart_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_dbus.sv
`default_nettype none
// ============================================================================
// Module   : if_dbus
// Purpose  : J1 data-bus: word address, read/write strobes, write/read data
// Revision : 1.0 - initial release
// ============================================================================
interface if_dbus;
    logic [15:0] adr;
    logic        re;
    logic        we;
    logic [15:0] dat_o;
    logic [15:0] dat_i;

    modport master (output adr, output re, output we, output dat_o, input dat_i);
    modport slave  (input adr, input re, input we, input dat_o, output dat_i);
endinterface
`default_nettype wire

// File: rtl/j1_dbus_uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Show-ahead synchronous FIFO with wrap-bit full/empty detection
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // A pop frees the slot on the same edge, so a full FIFO still accepts a push.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end
endmodule
`default_nettype wire

// File: rtl/j1_dbus_uart.sv
`default_nettype none
// ============================================================================
// Module   : j1_dbus_uart
// Purpose  : Memory-mapped 8N1 UART with TX/RX FIFOs on the J1 data bus
// Revision : 1.0 - initial release
// ============================================================================
module j1_dbus_uart
    import j1_dbus_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADR   = 16'h7FF0,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic   clk,
    input  logic   reset_n,
    if_dbus.slave  dbus,
    output logic   txd,
    input  logic   rxd
);
    logic        sel, rd_en, wr_en;
    logic [1:0]  off;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_dout;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_dout;
    logic [15:0] status_w;

    logic [15:0] div_q, div_d;
    logic [15:0] dat_i_q, dat_i_d;
    logic        tx_drop_q, tx_drop_d;
    logic        rx_ovr_q, rx_ovr_d;

    uart_state_t tx_state_q;
    logic [15:0] tx_div_q, tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        txd_q, tx_cnt_done;

    uart_state_t rx_state_q;
    logic [15:0] rx_div_q, rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_cnt_done;

    assign sel     = (dbus.adr[15:2] == BASE_ADR[15:2]);
    assign off     = dbus.adr[1:0];
    assign rd_en   = dbus.re & sel;
    assign wr_en   = dbus.we & sel;
    assign tx_push = wr_en & (off == REG_DATA);
    assign rx_pop  = rd_en & (off == REG_DATA);

    assign tx_cnt_done = (tx_cnt_q == 16'd1);
    assign rx_cnt_done = (rx_cnt_q == 16'd1);
    // The shifter takes a byte from IDLE, or straight from the end of STOP for gapless frames.
    assign tx_pop  = ~tx_empty & ((tx_state_q == US_IDLE) || ((tx_state_q == US_STOP) && tx_cnt_done));
    assign rx_push = (rx_state_q == US_STOP) & rx_cnt_done & rx_s2_q;

    assign txd       = txd_q;
    assign dbus.dat_i = dat_i_q;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .push(tx_push), .pop(tx_pop),
        .din(dbus.dat_o[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(rx_pop),
        .din(rx_shift_q), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        status_w              = '0;
        status_w[ST_TX_IDLE]  = tx_empty & (tx_state_q == US_IDLE);
        status_w[ST_TX_FULL]  = tx_full;
        status_w[ST_RX_VALID] = ~rx_empty;
        status_w[ST_RX_FULL]  = rx_full;
        status_w[ST_TX_DROP]  = tx_drop_q;
        status_w[ST_RX_OVR]   = rx_ovr_q;

        div_d     = div_q;
        dat_i_d   = dat_i_q;
        tx_drop_d = tx_drop_q;
        rx_ovr_d  = rx_ovr_q;

        if (wr_en && (off == REG_DIV)) begin
            div_d = clamp_div(dbus.dat_o);
        end
        if (wr_en && (off == REG_STATUS)) begin
            if (dbus.dat_o[ST_TX_DROP]) tx_drop_d = 1'b0;
            if (dbus.dat_o[ST_RX_OVR])  rx_ovr_d  = 1'b0;
        end
        // A new overflow in the same cycle as a clear wins.
        if (tx_push && tx_full && !tx_pop) tx_drop_d = 1'b1;
        if (rx_push && rx_full && !rx_pop) rx_ovr_d  = 1'b1;

        if (rd_en) begin
            case (off)
                REG_DATA:   dat_i_d = rx_empty ? RX_EMPTY_WORD : {8'h00, rx_dout};
                REG_STATUS: dat_i_d = status_w;
                REG_DIV:    dat_i_d = div_q;
                default:    dat_i_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= DIV_RESET;
            dat_i_q   <= 16'h0000;
            tx_drop_q <= 1'b0;
            rx_ovr_q  <= 1'b0;
        end else begin
            div_q     <= div_d;
            dat_i_q   <= dat_i_d;
            tx_drop_q <= tx_drop_d;
            rx_ovr_q  <= rx_ovr_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= US_IDLE;
            tx_div_q   <= DIV_RESET;
            tx_cnt_q   <= 16'd1;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                US_IDLE, US_STOP: begin
                    if ((tx_state_q == US_STOP) && !tx_cnt_done) begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end else if (tx_pop) begin
                        tx_state_q <= US_START;
                        tx_div_q   <= div_q;
                        tx_cnt_q   <= div_q;
                        tx_shift_q <= tx_dout;
                        txd_q      <= 1'b0;
                    end else begin
                        tx_state_q <= US_IDLE;
                    end
                end
                US_START: begin
                    if (tx_cnt_done) begin
                        tx_state_q <= US_DATA;
                        tx_cnt_q   <= tx_div_q;
                        tx_bit_q   <= 3'd0;
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                US_DATA: begin
                    if (tx_cnt_done) begin
                        tx_cnt_q <= tx_div_q;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= US_STOP;
                            txd_q      <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                default: tx_state_q <= US_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= US_IDLE;
            rx_div_q   <= DIV_RESET;
            rx_cnt_q   <= 16'd1;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
        end else begin
            rx_s1_q   <= rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            case (rx_state_q)
                US_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= US_START;
                        rx_div_q   <= div_q;
                        rx_cnt_q   <= {1'b0, div_q[15:1]};
                    end
                end
                US_START: begin
                    // Half a bit in: a line already back high was only a glitch.
                    if (rx_cnt_done) begin
                        if (rx_s2_q) begin
                            rx_state_q <= US_IDLE;
                        end else begin
                            rx_state_q <= US_DATA;
                            rx_cnt_q   <= rx_div_q;
                            rx_bit_q   <= 3'd0;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                US_DATA: begin
                    if (rx_cnt_done) begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= rx_div_q;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= US_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                US_STOP: begin
                    if (rx_cnt_done) begin
                        rx_state_q <= US_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                default: rx_state_q <= US_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_j1_dbus_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_j1_dbus_uart
// Purpose  : Scoreboard bench: bus reads and serial TX frames checked against
//            a queue-based model of the UART register file and FIFOs
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_j1_dbus_uart;
    import j1_dbus_uart_pkg::*;

    localparam logic [15:0] BASE = 16'h7FF0;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rxd     = 1'b1;
    logic txd;

    if_dbus bus();

    j1_dbus_uart #(.BASE_ADR(BASE), .FIFO_DEPTH(16), .DIV_RESET(16'd434)) dut (
        .clk(clk), .reset_n(reset_n), .dbus(bus), .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] rd_exp[$];
    string       rd_name[$];
    logic [7:0]  tx_exp[$];
    logic [7:0]  rx_m[$];
    bit          rx_ovr_m  = 1'b0;
    bit          tx_drop_m = 1'b0;
    int          model_div = 434;
    bit          mon_en    = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_data();
        if (rx_m.size() == 0) return 16'h8000;
        return {8'h00, rx_m.pop_front()};
    endfunction

    function automatic logic [15:0] exp_status(input bit txf, input bit txi);
        return {10'b0, rx_ovr_m, tx_drop_m, (rx_m.size() == 16), (rx_m.size() != 0), txf, txi};
    endfunction

    task automatic wr(input logic [15:0] adr, input logic [15:0] d);
        @(negedge clk);
        bus.adr = adr; bus.dat_o = d; bus.we = 1'b1;
        @(posedge clk);
        #1 bus.we = 1'b0;
    endtask

    task automatic wr_div(input int v);
        wr(BASE | 16'd2, 16'(v));
        model_div = (v < 4) ? 4 : v;
    endtask

    task automatic rd(input logic [1:0] off, input logic [15:0] exp, input string name);
        @(negedge clk);
        bus.adr = BASE | {14'b0, off}; bus.re = 1'b1;
        rd_exp.push_back(exp);
        rd_name.push_back(name);
        @(posedge clk);
        #1 bus.re = 1'b0;
    endtask

    task automatic drive_bit(input logic v, input int per);
        @(negedge clk);
        rxd = v;
        repeat (per - 1) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_ok);
        int per;
        per = model_div;
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(b[i], per);
        drive_bit(stop_ok, per);
        drive_bit(1'b1, per);
        drive_bit(1'b1, per);
        if (stop_ok) begin
            if (rx_m.size() < 16) rx_m.push_back(b);
            else rx_ovr_m = 1'b1;
        end
    endtask

    task automatic wait_tx_drain(input int budget);
        int n;
        n = 0;
        while (tx_exp.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (tx_exp.size() != 0) begin
            checks++; errors++;
            $display("FAIL tx_drain_timeout actual=%0d required=0", tx_exp.size());
            tx_exp.delete();
        end
        repeat (model_div) @(negedge clk);
    endtask

    // Read-data monitor: every selected re edge must present the queued word one cycle later.
    initial begin
        forever begin
            @(posedge clk);
            if (reset_n && bus.re && (bus.adr[15:2] == BASE[15:2])) begin
                #1;
                if (rd_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read actual=%h required=none", bus.dat_i);
                end else begin
                    chk(rd_name.pop_front(), bus.dat_i, rd_exp.pop_front());
                end
            end
        end
    end

    // Serial TX monitor: decodes each 8N1 frame mid-bit and pops the expected byte.
    initial begin
        logic       prev;
        logic       st, stp;
        logic [7:0] b;
        int         per;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && reset_n && prev && !txd) begin
                per = model_div;
                repeat (per / 2) @(negedge clk);
                st = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (per) @(negedge clk);
                    b[i] = txd;
                end
                repeat (per) @(negedge clk);
                stp = txd;
                if (tx_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected_frame actual=%h required=none", b);
                end else begin
                    chk("tx_frame", {6'b0, st, stp, b}, {6'b0, 1'b0, 1'b1, tx_exp.pop_front()});
                end
                prev = 1'b1;
            end else begin
                prev = txd;
            end
        end
    end

    initial begin
        #500_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int         n, lo, cnt, txcnt;
        logic [7:0] b;
        bus.adr = 16'h0000; bus.re = 1'b0; bus.we = 1'b0; bus.dat_o = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_txd", {15'b0, txd}, 16'h0001);
        chk("reset_dat_i", bus.dat_i, 16'h0000);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        rd(REG_STATUS, exp_status(1'b0, 1'b1), "status_reset");
        rd(REG_DIV, 16'(model_div), "div_reset");
        rd(2'd3, 16'h0000, "reg3_read");
        rd(REG_DATA, exp_data(), "data_empty_reset");

        wr_div(2);
        rd(REG_DIV, 16'(model_div), "div_clamp_2");
        wr_div(8);
        rd(REG_DIV, 16'(model_div), "div_8");
        @(negedge clk);
        bus.adr = 16'h1232; bus.re = 1'b1;
        @(posedge clk);
        #1 bus.re = 1'b0;
        chk("unsel_read_hold", bus.dat_i, 16'd8);
        wr(16'h1232, 16'd99);
        rd(REG_DIV, 16'(model_div), "div_unsel_write");

        tx_exp.push_back(8'hA5);
        wr(BASE, 16'h00A5);
        n = 0;
        while (txd !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        lo = 0;
        while (txd === 1'b0 && lo < 100) begin @(negedge clk); lo++; end
        chk("tx_start_width", 16'(lo), 16'd8);
        wait_tx_drain(400);
        rd(REG_STATUS, exp_status(1'b0, 1'b1), "status_tx_idle");

        tx_exp.push_back(8'h5A);
        wr(BASE, 16'h005A);
        repeat (20) @(negedge clk);
        wr_div(16);
        wait_tx_drain(600);

        for (int k = 0; k < 4; k++) begin
            wr_div(int'($urandom_range(4, 12)));
            n = int'($urandom_range(1, 5));
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                tx_exp.push_back(b);
                wr(BASE, {8'h00, b});
            end
            wait_tx_drain(2000);
        end
        rd(REG_STATUS, exp_status(1'b0, 1'b1), "status_after_tx");

        wr_div(8);
        send_rx(8'h3C, 1'b1);
        rd(REG_STATUS, exp_status(1'b0, 1'b1), "status_rx_valid");
        rd(REG_DATA, exp_data(), "rx_data_3c");
        rd(REG_DATA, exp_data(), "rx_data_then_empty");

        @(negedge clk); rxd = 1'b0;
        @(negedge clk); rxd = 1'b1;
        repeat (40) @(negedge clk);
        rd(REG_DATA, exp_data(), "rx_glitch");

        send_rx(8'($urandom), 1'b0);
        rd(REG_DATA, exp_data(), "rx_framing");

        for (int k = 0; k < 3; k++) begin
            wr_div(int'($urandom_range(4, 12)));
            for (int j = 0; j < 4; j++) send_rx(8'($urandom), ($urandom_range(0, 3) != 0));
            rd(REG_STATUS, exp_status(1'b0, 1'b1), "status_rx_rand");
            cnt = rx_m.size() + 1;
            for (int j = 0; j < cnt; j++) rd(REG_DATA, exp_data(), "rx_rand_data");
        end

        wr_div(8);
        for (int j = 0; j < 17; j++) send_rx(8'($urandom), 1'b1);
        rd(REG_STATUS, exp_status(1'b0, 1'b1), "status_rx_ovr");
        for (int j = 0; j < 16; j++) rd(REG_DATA, exp_data(), "rx_ovr_data");
        rd(REG_DATA, exp_data(), "rx_ovr_empty");
        rd(REG_STATUS, exp_status(1'b0, 1'b1), "status_ovr_sticky");
        wr(BASE | 16'd1, 16'h0020);
        rx_ovr_m = 1'b0;
        rd(REG_STATUS, exp_status(1'b0, 1'b1), "status_ovr_clr");

        mon_en = 1'b0;
        wr_div(1000);
        wr(BASE, 16'h0011);
        repeat (5) @(negedge clk);
        txcnt = 0;
        for (int j = 0; j < 17; j++) begin
            b = 8'($urandom);
            wr(BASE, {8'h00, b});
            if (txcnt < 16) txcnt++;
            else tx_drop_m = 1'b1;
        end
        rd(REG_STATUS, exp_status(txcnt == 16, 1'b0), "status_tx_drop");
        wr(BASE | 16'd1, 16'h0010);
        tx_drop_m = 1'b0;
        rd(REG_STATUS, exp_status(txcnt == 16, 1'b0), "status_drop_clr");
        chk("txd_midframe_low", {15'b0, txd}, 16'h0000);

        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("txd_async_reset", {15'b0, txd}, 16'h0001);
        chk("dat_i_async_reset", bus.dat_i, 16'h0000);
        rx_m.delete();
        rx_ovr_m  = 1'b0;
        tx_drop_m = 1'b0;
        model_div = 434;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd(REG_STATUS, exp_status(1'b0, 1'b1), "status_after_reset");
        rd(REG_DIV, 16'(model_div), "div_after_reset");

        repeat (5) @(negedge clk);
        chk("read_queue_drained", 16'(rd_exp.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
